// File: rtl/prog_dly_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_dly_pkg
//  Purpose  : Shared types and helpers for the programmable delay shift
//             register: FSM state encoding and the delay-select clamp.
//  Revision : 1.0  initial release
// ============================================================================
package prog_dly_pkg;

    // RUN : pipeline contents valid at the selected tap
    // FILL: pipeline refilling after a delay change or flush
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Clamp a requested delay into 1..max_dly.
    function automatic logic [31:0] clamp_dly(input logic [31:0] sel,
                                              input logic [31:0] max_dly);
        if (sel == 32'd0) begin
            return 32'd1;
        end else if (sel > max_dly) begin
            return max_dly;
        end else begin
            return sel;
        end
    endfunction

endpackage : prog_dly_pkg
`default_nettype wire

// File: rtl/prog_dly_tap_mux.sv
`default_nettype none
// ============================================================================
//  Module   : prog_dly_tap_mux
//  Purpose  : DEPTH-to-1 tap selector over the delay-line stages.
//  Ports    : i_taps  - stage contents, index 0 = youngest stage
//             i_sel   - stage index to present
//             o_tap   - selected stage contents
//  Revision : 1.0  initial release
// ============================================================================
module prog_dly_tap_mux #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    parameter int SEL_W = 5
) (
    input  logic [WIDTH-1:0] i_taps [DEPTH],
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_tap
);

    always_comb begin
        o_tap = i_taps[0];
        for (int k = 1; k < DEPTH; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_tap = i_taps[k];
            end
        end
    end

endmodule : prog_dly_tap_mux
`default_nettype wire

// File: rtl/prog_dly_sr.sv
`default_nettype none
// ============================================================================
//  Module   : prog_dly_sr
//  Purpose  : Programmable-delay shift register for VEC lanes of DSIZE bits.
//             Output is taken from stage dly_cur-1, giving dly_cur en-cycles
//             of latency. Changing the delay or flushing invalidates the
//             pipeline; busy stays high until it has refilled.
//  Ports    : clk, rst_b (async, active-low)
//             en       - advance pipeline      flush   - invalidate samples
//             dly_sel  - requested delay       din_vld/din   - input sample
//             dout_vld/dout - delayed sample   dly_cur - delay in force
//             busy     - refilling after change/flush
//  Revision : 1.0  initial release
// ============================================================================
module prog_dly_sr
    import prog_dly_pkg::*;
#(
    parameter int DSIZE   = 8,
    parameter int VEC     = 4,
    parameter int MAX_DLY = 16,
    parameter int DLY_W   = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             flush,
    input  logic [DLY_W-1:0] dly_sel,
    input  logic             din_vld,
    input  logic [DSIZE-1:0] din [VEC],
    output logic             dout_vld,
    output logic [DSIZE-1:0] dout [VEC],
    output logic [DLY_W-1:0] dly_cur,
    output logic             busy
);

    localparam int LW = VEC * DSIZE;
    localparam int TW = LW + 1;

    logic [DLY_W-1:0] w_dly_clamp;
    logic             w_chg;
    logic             w_clr;
    logic [LW-1:0]    w_din_flat;
    logic [TW-1:0]    w_taps [MAX_DLY];
    logic [TW-1:0]    w_tap_out;
    logic [DLY_W-1:0] w_tap_sel;

    logic [MAX_DLY-1:0] r_vld;
    logic [LW-1:0]      r_data [MAX_DLY];
    state_t             r_state;
    logic [DLY_W-1:0]   r_dly_cur;
    logic [DLY_W-1:0]   r_fill_cnt;

    state_t             w_state_nxt;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic [DLY_W-1:0]   w_cnt_nxt;

    assign w_dly_clamp = DLY_W'(clamp_dly(32'(dly_sel), 32'(MAX_DLY)));
    // A delay mismatch clears the pipeline whether or not en is high.
    assign w_chg       = (w_dly_clamp != r_dly_cur);
    assign w_clr       = w_chg | flush;

    for (genvar i = 0; i < VEC; i++) begin : g_lane
        assign w_din_flat[i*DSIZE +: DSIZE] = din[i];
        assign dout[i]                      = w_tap_out[i*DSIZE +: DSIZE];
    end

    // Valid bits clear on a clear edge and the incoming sample is dropped;
    // data bits simply hold, since nothing downstream looks at them unqualified.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_vld <= '0;
            for (int k = 0; k < MAX_DLY; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_clr) begin
                r_vld <= '0;
            end else if (en) begin
                r_vld <= {r_vld[MAX_DLY-2:0], din_vld};
            end
            if (en && !w_clr) begin
                r_data[0] <= w_din_flat;
                for (int k = 1; k < MAX_DLY; k++) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= ST_RUN;
            r_dly_cur  <= DLY_W'(1);
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dly_cur  <= w_dly_nxt;
            r_fill_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly_cur;
        w_cnt_nxt   = r_fill_cnt;
        if (w_clr) begin
            w_state_nxt = ST_FILL;
            w_dly_nxt   = w_dly_clamp;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_FILL && en) begin
            // The dly_cur-th en edge after the clear lands the first new
            // sample on the output tap.
            if (r_fill_cnt == r_dly_cur - DLY_W'(1)) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_fill_cnt + DLY_W'(1);
            end
        end
    end

    for (genvar k = 0; k < MAX_DLY; k++) begin : g_tap
        assign w_taps[k] = {r_vld[k], r_data[k]};
    end

    assign w_tap_sel = r_dly_cur - DLY_W'(1);

    prog_dly_tap_mux #(
        .WIDTH (TW),
        .DEPTH (MAX_DLY),
        .SEL_W (DLY_W)
    ) u_tap_mux (
        .i_taps (w_taps),
        .i_sel  (w_tap_sel),
        .o_tap  (w_tap_out)
    );

    assign dout_vld = w_tap_out[TW-1];
    assign dly_cur  = r_dly_cur;
    assign busy     = (r_state == ST_FILL);

endmodule : prog_dly_sr
`default_nettype wire
